mmio_io_ctrl: RTL and testbench
===============================

# mmio_io_ctrl

Memory-mapped I/O controller between the CPU's execute/memory stage and the on-chip UART and performance counters. It decodes loads and stores in the 0x8000_0000 I/O region and owns the UART transmit holding register and a small receive FIFO. It also maintains cycle and retired-instruction counters. Read data is registered so it arrives in the same cycle slot as synchronous dmem data, and the writeback mux selects it with `rdata_sel`.

## Interface
Parameters:
- `IO_BASE`, default 32'h8000_0000. Base of the I/O region; decoding compares `req_addr[31:28]` to `IO_BASE[31:28]`.
- `RX_DEPTH`, default 4. Receive FIFO depth; must be a power of two, ≥2.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_addr`  in  32  byte address from the execute-stage ALU.
- `req_wdata`  in  32  store data.
- `req_we`  in  4  store byte enables; any nonzero bit means a write.
- `req_re`  in  1  load request.
- `inst_retire`  in  1  one-cycle pulse per committed (non-bubble) instruction.
- `rdata`  out  32  registered load data.
- `rdata_sel`  out  1  registered; 1 when `rdata` holds an I/O load result.
- `uart_tx_data`  out  8  byte to the UART transmitter.
- `uart_tx_valid`  out  1  transmit valid.
- `uart_tx_ready`  in  1  transmitter ready.
- `uart_rx_data`  in  8  received byte.
- `uart_rx_valid`  in  1  receive valid.
- `uart_rx_ready`  out  1  FIFO can accept a byte.

## Operation
A request is a hit when `req_addr[31:28]==IO_BASE[31:28]`. The offset is `req_addr[7:0]`; upper offset bits other than [31:28] are ignored.

Register map:
- 0x00, read-only status: {30'b0, rx_nonempty, tx_empty}.
- 0x04, read-only receive data: {24'b0, FIFO head}. A read pops the FIFO if it is nonempty. A read when empty returns 0 and does not move the pointers.
- 0x08, write-only transmit data: `req_wdata[7:0]`. The write is accepted only when the holding register is empty; otherwise it is silently dropped.
- 0x10, read-only cycle counter.
- 0x14, read-only retired-instruction counter.
- 0x18, write-only counter reset. Any write clears both counters.
- Any other offset reads 0; writes to it are ignored. Writes to read-only offsets and reads of write-only offsets are ignored and return 0.

Transmit path:
- A single holding register with a `tx_full` flag. `uart_tx_valid = tx_full` and `uart_tx_data` = the held byte.
- `tx_full` clears on the cycle where `uart_tx_valid && uart_tx_ready`.
- If the handshake and a 0x08 write occur in the same cycle while full, the write is dropped because status showed not-empty.

Receive path:
- A circular FIFO with read/write pointers and an occupancy count.
- `uart_rx_ready = !full`, so it is 1 while in reset.
- A push happens on `uart_rx_valid && uart_rx_ready`.
- A push and a pop in the same cycle both occur and the count is unchanged. When full, ready is low, so a same-cycle pop does not enable a push.
- Pointers wrap modulo `RX_DEPTH`.

Counters:
- 32-bit, wrapping at 2^32.
- The cycle counter increments every cycle.
- The instruction counter increments when `inst_retire` is high.
- A 0x18 write takes priority over the increment: the next value is 0.

## Timing
- Load latency: 1 cycle. A hit with `req_re` at edge N produces `rdata` and `rdata_sel=1` after edge N+1.
- Returned data is the register value before edge N+1 (pre-increment counters, pre-pop FIFO head).
- A non-hit or no-read cycle gives `rdata=0` and `rdata_sel=0` on the following cycle.
- Store side effects (tx load, counter clear) become visible one cycle after the request edge. Status read in the cycle after a tx write shows `tx_empty=0`.
- Reset values: `rdata=0`, `rdata_sel=0`, `uart_tx_valid=0`, `uart_tx_data=0`, `uart_rx_ready=1`, counters 0, FIFO empty.
- Reset asserted mid-operation discards any pending tx byte and all buffered rx bytes immediately (asynchronously).
- `req_re` and a nonzero `req_we` in the same cycle: the write is performed, and the read returns data per the map.

## Test plan
- Reset, then read 0x00 → `rdata=32'h1`, `rdata_sel=1` one cycle later. Then read 0x10 three cycles after reset release → value 3 (±0 against the bench's own cycle model).
- Write 0x41 to 0x08 with `uart_tx_ready=0` → `uart_tx_valid=1`, data 0x41. Then write 0x42 → dropped. Raise ready → one handshake carrying 0x41, `uart_tx_valid` falls, status bit0 returns to 1.
- Push bytes 0x10, 0x11, 0x12, 0x13 → `uart_rx_ready=0`. Read 0x04 four times → returns 0x10..0x13 in order. A fifth read → 0; status bit1 =0.
- With FIFO holding 2 bytes, push one and pop one in the same cycle → count stays 2 and order is preserved across pointer wrap.
- Pulse `inst_retire` 5 times, write 0x18 in the same cycle as a retire → both counters read 0 next cycle. Preload the cycle counter near 32'hFFFF_FFFF via a long run or force → wraps to 0.
- Assert `rst_n` low mid-transmit with 3 rx bytes buffered → outputs return to reset values immediately, and status reads 32'h1 after release.

Source files
------------

// File: rtl/mmio_io_ctrl.sv
// mmio_io_ctrl: memory-mapped I/O block for the core's memory stage.
// Decodes the I/O region and owns the UART transmit holding register, a small
// receive FIFO, and the cycle / retired-instruction counters. Load data is
// registered so it lines up with synchronous dmem read data.
//
// Handshake semantics: a byte moves across a UART interface on a rising clk
// edge where both valid and ready are high; valid never depends on ready, and
// a producer holds its data stable while valid is high and ready is low.
module mmio_io_ctrl #(
    parameter logic [31:0] IO_BASE  = 32'h8000_0000,
    parameter int          RX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_we,
    input  logic        req_re,
    input  logic        inst_retire,
    output logic [31:0] rdata,
    output logic        rdata_sel,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready
);

    localparam int AW = $clog2(RX_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [7:0] OFF_STATUS = 8'h00;
    localparam logic [7:0] OFF_RXDATA = 8'h04;
    localparam logic [7:0] OFF_TXDATA = 8'h08;
    localparam logic [7:0] OFF_CYCLE  = 8'h10;
    localparam logic [7:0] OFF_INSTR  = 8'h14;
    localparam logic [7:0] OFF_CLEAR  = 8'h18;

    // Request decode
    logic       hit;
    logic [7:0] off;
    logic       is_rd;
    logic       is_wr;

    assign hit   = (req_addr[31:28] == IO_BASE[31:28]);
    assign off   = req_addr[7:0];
    assign is_rd = hit && req_re;
    assign is_wr = hit && (req_we != 4'b0000);

    // Transmit holding register
    logic       tx_full;
    logic [7:0] tx_data;
    logic       tx_hs;
    logic       tx_load;

    assign tx_hs         = tx_full && uart_tx_ready;
    // A write while full is dropped even if the handshake frees the slot this cycle.
    assign tx_load       = is_wr && (off == OFF_TXDATA) && !tx_full;
    assign uart_tx_valid = tx_full;
    assign uart_tx_data  = tx_data;

    // Receive FIFO
    logic [7:0]    rx_mem [RX_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] rx_count;
    logic          rx_full;
    logic          rx_nonempty;
    logic          rx_push;
    logic          rx_pop;

    assign rx_full       = (rx_count == CW'(RX_DEPTH));
    assign rx_nonempty   = (rx_count != '0);
    assign uart_rx_ready = !rx_full;
    assign rx_push       = uart_rx_valid && !rx_full;
    assign rx_pop        = is_rd && (off == OFF_RXDATA) && rx_nonempty;

    // Counters
    logic [31:0] cyc_cnt;
    logic [31:0] inst_cnt;
    logic        cnt_clr;

    assign cnt_clr = is_wr && (off == OFF_CLEAR);

    // Transmit holding register: load when empty, drain on handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_full <= 1'b0;
            tx_data <= 8'h00;
        end else if (tx_load) begin
            tx_full <= 1'b1;
            tx_data <= req_wdata[7:0];
        end else if (tx_hs) begin
            tx_full <= 1'b0;
        end
    end

    // Receive FIFO storage; contents are only observable while counted
    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[wr_ptr] <= uart_rx_data;
        end
    end

    // Receive FIFO pointers and occupancy; pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rx_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + CW'(1);
                2'b01:   rx_count <= rx_count - CW'(1);
                default: rx_count <= rx_count;
            endcase
        end
    end

    // Performance counters; a clear write wins over the increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt  <= 32'h0;
            inst_cnt <= 32'h0;
        end else if (cnt_clr) begin
            cyc_cnt  <= 32'h0;
            inst_cnt <= 32'h0;
        end else begin
            cyc_cnt  <= cyc_cnt + 32'h1;
            inst_cnt <= inst_cnt + {31'h0, inst_retire};
        end
    end

    // Read mux over pre-edge register values
    logic [31:0] rd_val;
    always_comb begin
        rd_val = 32'h0;
        case (off)
            OFF_STATUS: rd_val = {30'h0, rx_nonempty, !tx_full};
            OFF_RXDATA: rd_val = rx_nonempty ? {24'h0, rx_mem[rd_ptr]} : 32'h0;
            OFF_CYCLE:  rd_val = cyc_cnt;
            OFF_INSTR:  rd_val = inst_cnt;
            default:    rd_val = 32'h0;
        endcase
    end

    // Registered load response; zero whenever no I/O load was issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata     <= 32'h0;
            rdata_sel <= 1'b0;
        end else begin
            rdata     <= is_rd ? rd_val : 32'h0;
            rdata_sel <= is_rd;
        end
    end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Bench for mmio_io_ctrl: directed scenarios plus a randomized phase, with a
// queue-based model of the register map and a monitor on the load response.
module tb_mmio_io_ctrl;

    localparam int RX_DEPTH = 4;

    // Clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_we = '0;
    logic        req_re = 1'b0;
    logic        inst_retire = 1'b0;
    logic [31:0] rdata;
    logic        rdata_sel;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready = 1'b0;
    logic [7:0]  uart_rx_data = '0;
    logic        uart_rx_valid = 1'b0;
    logic        uart_rx_ready;

    mmio_io_ctrl #(.IO_BASE(32'h8000_0000), .RX_DEPTH(RX_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_we(req_we), .req_re(req_re),
        .inst_retire(inst_retire),
        .rdata(rdata), .rdata_sel(rdata_sel),
        .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
        .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard: {rdata_sel, rdata} expected after each driven edge
    logic [32:0] exp_q[$];

    // Reference model state
    logic        m_tx_full;
    logic [7:0]  m_tx_data;
    logic [7:0]  m_rx_q[$];
    logic [31:0] m_cyc;
    logic [31:0] m_inst;
    logic        txr_hold = 1'b0;

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_tx_full = 1'b0;
        m_tx_data = 8'h00;
        m_rx_q.delete();
        m_cyc  = 32'h0;
        m_inst = 32'h0;
        exp_q.delete();
    endtask

    // One clock of stimulus; checks interface state, drives, predicts
    task automatic step(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wd,
                        input logic re, input logic ret, input logic rxv, input logic [7:0] rxd,
                        input logic txr);
        logic        hit;
        logic [7:0]  off;
        logic        is_rd;
        logic        is_wr;
        logic [31:0] rv;
        logic        push_ok;
        @(negedge clk);
        chk("tx_valid", {32'h0, uart_tx_valid}, {32'h0, m_tx_full});
        chk("tx_data", {25'h0, uart_tx_data}, {25'h0, m_tx_data});
        chk("rx_ready", {32'h0, uart_rx_ready}, {32'h0, (m_rx_q.size() < RX_DEPTH)});
        req_addr = addr; req_we = we; req_wdata = wd; req_re = re;
        inst_retire = ret; uart_rx_valid = rxv; uart_rx_data = rxd; uart_tx_ready = txr;
        hit   = (addr[31:28] == 4'h8);
        off   = addr[7:0];
        is_rd = hit && re;
        is_wr = hit && (we != 4'h0);
        rv = 32'h0;
        if (is_rd) begin
            case (off)
                8'h00: rv = {30'h0, (m_rx_q.size() != 0), !m_tx_full};
                8'h04: rv = (m_rx_q.size() != 0) ? {24'h0, m_rx_q[0]} : 32'h0;
                8'h10: rv = m_cyc;
                8'h14: rv = m_inst;
                default: rv = 32'h0;
            endcase
        end
        exp_q.push_back({is_rd, rv});
        push_ok = rxv && (m_rx_q.size() < RX_DEPTH);
        if (is_rd && off == 8'h04 && m_rx_q.size() != 0) void'(m_rx_q.pop_front());
        if (push_ok) m_rx_q.push_back(rxd);
        if (is_wr && off == 8'h08 && !m_tx_full) begin
            m_tx_full = 1'b1;
            m_tx_data = wd[7:0];
        end else if (m_tx_full && txr) begin
            m_tx_full = 1'b0;
        end
        if (is_wr && off == 8'h18) begin
            m_cyc  = 32'h0;
            m_inst = 32'h0;
        end else begin
            m_cyc  = m_cyc + 32'h1;
            m_inst = m_inst + {31'h0, ret};
        end
    endtask

    task automatic idle();
        step(32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 8'h0, txr_hold);
    endtask

    task automatic rd(input logic [7:0] off);
        step({24'h800000, off}, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 8'h0, txr_hold);
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        step({24'h800000, off}, 4'hF, d, 1'b0, 1'b0, 1'b0, 8'h0, txr_hold);
    endtask

    task automatic push(input logic [7:0] b);
        step(32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, b, txr_hold);
    endtask

    // Asynchronous reset away from both clock edges, with immediate output checks
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        req_addr = '0; req_we = '0; req_wdata = '0; req_re = 1'b0; inst_retire = 1'b0;
        uart_rx_valid = 1'b0; uart_rx_data = '0; uart_tx_ready = 1'b0; txr_hold = 1'b0;
        #1;
        chk("rst_tx_valid", {32'h0, uart_tx_valid}, 33'h0);
        chk("rst_tx_data", {25'h0, uart_tx_data}, 33'h0);
        chk("rst_rx_ready", {32'h0, uart_rx_ready}, 33'h1);
        chk("rst_rdata", {rdata_sel, rdata}, 33'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: compare the registered load response after every driven edge
    always @(posedge clk) begin
        logic [32:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rdata", {rdata_sel, rdata}, e);
        end
    end

    // Safety net against a stalled run
    initial begin
        #2ms;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        do_reset();

        // Status after reset, then the cycle counter three cycles on
        rd(8'h00);
        idle();
        idle();
        rd(8'h10);

        // Transmit: accept, drop while full, drain on handshake
        wr(8'h08, 32'h0000_0041);
        idle();
        wr(8'h08, 32'h0000_0042);
        rd(8'h00);
        txr_hold = 1'b1;
        idle();
        idle();
        txr_hold = 1'b0;
        rd(8'h00);

        // Receive: fill, overflow attempt, drain past empty
        push(8'h10);
        push(8'h11);
        push(8'h12);
        push(8'h13);
        push(8'h99);
        for (int i = 0; i < 5; i++) rd(8'h04);
        rd(8'h00);

        // Same-cycle push and pop across the pointer wrap
        push(8'h20);
        push(8'h21);
        step(32'h8000_0004, 4'h0, 32'h0, 1'b1, 1'b0, 1'b1, 8'h22, 1'b0);
        step(32'h8000_0004, 4'h0, 32'h0, 1'b1, 1'b0, 1'b1, 8'h23, 1'b0);
        for (int i = 0; i < 3; i++) rd(8'h04);
        rd(8'h00);

        // Retire counting and clear-with-retire priority
        for (int i = 0; i < 5; i++) step(32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, 8'h0, 1'b0);
        rd(8'h14);
        step(32'h8000_0018, 4'h1, 32'h0, 1'b0, 1'b1, 1'b0, 8'h0, 1'b0);
        rd(8'h10);
        rd(8'h14);

        // Cycle counter wrap via preload just before an edge
        idle();
        force dut.cyc_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.cyc_cnt;
        m_cyc = 32'hFFFF_FFFF;
        rd(8'h10);
        rd(8'h10);

        // Randomized traffic over the whole map, hits and misses
        for (int n = 0; n < 400; n++) begin
            logic [7:0]  offs [8];
            logic [31:0] a;
            logic [3:0]  top;
            int          sel;
            offs[0] = 8'h00; offs[1] = 8'h04; offs[2] = 8'h08; offs[3] = 8'h0C;
            offs[4] = 8'h10; offs[5] = 8'h14; offs[6] = 8'h18; offs[7] = 8'h1C;
            sel = $urandom_range(0, 9);
            a = {4'h8, 20'($urandom), 8'h00};
            if (sel < 8) a[7:0] = offs[sel];
            else if (sel == 8) a[7:0] = 8'($urandom);
            else begin
                top = 4'($urandom_range(0, 15));
                if (top == 4'h8) top = 4'h9;
                a = {top, 20'($urandom), offs[$urandom_range(0, 7)]};
            end
            step(a, ($urandom_range(0, 9) < 3) ? 4'($urandom_range(1, 15)) : 4'h0,
                 $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) == 0), 8'($urandom), 1'($urandom_range(0, 1)));
        end
        idle();

        // Reset mid-transmit with bytes buffered
        wr(8'h08, 32'h0000_0055);
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        rd(8'h00);
        do_reset();
        rd(8'h00);
        idle();
        idle();

        @(posedge clk);
        #2;
        chk("exp_q_drained", 33'(exp_q.size()), 33'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
